// File: rtl/soc_system_clkgen_bank.sv
// rtl/soc_system_clkgen_bank.sv - multi-channel programmable clock divider bank with lock modelling
//
// Ports:
//   refclk    in   reference clock, all logic on its rising edge
//   rst       in   asynchronous active-high reset
//   cfg_wr    in   write cfg_div/cfg_high/cfg_phase into shadow set of channel cfg_sel
//   cfg_sel   in   channel index; out-of-range indices are ignored
//   cfg_div   in   divide ratio (0 disables the channel)
//   cfg_high  in   high time in refclk cycles
//   cfg_phase in   counter start value (treated as 0 when >= divide ratio)
//   cfg_apply in   copy shadow set to active set and relock
//   outclk    out  registered divided clocks
//   clk_en    out  registered one-cycle strobe on the last cycle of each period
//   locked    out  configuration settled, outputs valid

module soc_system_clkgen_bank #(
  parameter int NUM_CLOCKS    = 4,
  parameter int CNT_WIDTH     = 16,
  parameter int LOCK_CYCLES   = 16,
  parameter int DIV_DEFAULT   = 2,
  parameter int HIGH_DEFAULT  = 1,
  parameter int PHASE_DEFAULT = 0,
  localparam int SEL_W = (NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1
) (
  input  logic                  refclk,
  input  logic                  rst,
  input  logic                  cfg_wr,
  input  logic [SEL_W-1:0]      cfg_sel,
  input  logic [CNT_WIDTH-1:0]  cfg_div,
  input  logic [CNT_WIDTH-1:0]  cfg_high,
  input  logic [CNT_WIDTH-1:0]  cfg_phase,
  input  logic                  cfg_apply,
  output logic [NUM_CLOCKS-1:0] outclk,
  output logic [NUM_CLOCKS-1:0] clk_en,
  output logic                  locked
);

  localparam int SETTLE_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [SETTLE_W-1:0]  SETTLE_LAST  = SETTLE_W'(LOCK_CYCLES - 1);
  localparam logic [SEL_W:0]       NUM_CLOCKS_W = (SEL_W + 1)'(NUM_CLOCKS);
  localparam logic [CNT_WIDTH-1:0] ONE          = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] DIV_RST      = CNT_WIDTH'(DIV_DEFAULT);
  localparam logic [CNT_WIDTH-1:0] HIGH_RST     = CNT_WIDTH'(HIGH_DEFAULT);
  localparam logic [CNT_WIDTH-1:0] PHASE_RST    = CNT_WIDTH'(PHASE_DEFAULT);
  localparam logic [CNT_WIDTH-1:0] CNT_RST      = (PHASE_RST < DIV_RST) ? PHASE_RST : '0;

  typedef enum logic {
    ST_SETTLE = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t state, state_n;
  logic [SETTLE_W-1:0] settle_cnt, settle_cnt_n;

  // Shadow set takes writes; active set drives the counters.
  logic [CNT_WIDTH-1:0] sh_div    [NUM_CLOCKS];
  logic [CNT_WIDTH-1:0] sh_high   [NUM_CLOCKS];
  logic [CNT_WIDTH-1:0] sh_phase  [NUM_CLOCKS];
  logic [CNT_WIDTH-1:0] act_div   [NUM_CLOCKS];
  logic [CNT_WIDTH-1:0] act_high  [NUM_CLOCKS];
  logic [CNT_WIDTH-1:0] act_phase [NUM_CLOCKS];
  logic [CNT_WIDTH-1:0] cnt       [NUM_CLOCKS];

  logic [CNT_WIDTH-1:0] sh_div_n    [NUM_CLOCKS];
  logic [CNT_WIDTH-1:0] sh_high_n   [NUM_CLOCKS];
  logic [CNT_WIDTH-1:0] sh_phase_n  [NUM_CLOCKS];
  logic [CNT_WIDTH-1:0] act_div_n   [NUM_CLOCKS];
  logic [CNT_WIDTH-1:0] act_high_n  [NUM_CLOCKS];
  logic [CNT_WIDTH-1:0] act_phase_n [NUM_CLOCKS];
  logic [CNT_WIDTH-1:0] cnt_n       [NUM_CLOCKS];

  logic [NUM_CLOCKS-1:0] wr_hit;
  logic [NUM_CLOCKS-1:0] live;
  logic [NUM_CLOCKS-1:0] outclk_n;
  logic [NUM_CLOCKS-1:0] clk_en_n;
  logic                  sel_ok;
  logic                  run;

  // A start phase beyond the period would never be reached by the wrap
  // logic, so it collapses to zero.
  function automatic logic [CNT_WIDTH-1:0] phase_eff(input logic [CNT_WIDTH-1:0] phase,
                                                     input logic [CNT_WIDTH-1:0] div);
    return (phase < div) ? phase : '0;
  endfunction

  always_comb begin
    state_n      = state;
    settle_cnt_n = settle_cnt;
    sel_ok       = ({1'b0, cfg_sel} < NUM_CLOCKS_W);
    wr_hit       = '0;
    live         = '0;
    outclk_n     = '0;
    clk_en_n     = '0;

    unique case (state)
      ST_SETTLE: begin
        if (cfg_apply) begin
          settle_cnt_n = '0;
        end else if (settle_cnt == SETTLE_LAST) begin
          state_n      = ST_LOCKED;
          settle_cnt_n = '0;
        end else begin
          settle_cnt_n = settle_cnt + 1'b1;
        end
      end
      ST_LOCKED: begin
        if (cfg_apply) begin
          state_n      = ST_SETTLE;
          settle_cnt_n = '0;
        end
      end
      default: begin
        state_n      = ST_SETTLE;
        settle_cnt_n = '0;
      end
    endcase

    // Counters only free-run while staying locked; otherwise they are parked
    // at the effective start phase of the (possibly just applied) config so
    // that all channels restart phase-aligned on the lock edge.
    run = (state == ST_LOCKED) && !cfg_apply;

    for (int i = 0; i < NUM_CLOCKS; i++) begin
      wr_hit[i] = cfg_wr && sel_ok && (cfg_sel == SEL_W'(i));

      // A write in the same cycle as apply is folded into the applied set.
      sh_div_n[i]    = wr_hit[i] ? cfg_div   : sh_div[i];
      sh_high_n[i]   = wr_hit[i] ? cfg_high  : sh_high[i];
      sh_phase_n[i]  = wr_hit[i] ? cfg_phase : sh_phase[i];
      act_div_n[i]   = cfg_apply ? sh_div_n[i]   : act_div[i];
      act_high_n[i]  = cfg_apply ? sh_high_n[i]  : act_high[i];
      act_phase_n[i] = cfg_apply ? sh_phase_n[i] : act_phase[i];

      if (!run) begin
        cnt_n[i] = phase_eff(act_phase_n[i], act_div_n[i]);
      end else if (act_div[i] == '0) begin
        cnt_n[i] = '0;
      end else if (cnt[i] == act_div[i] - ONE) begin
        cnt_n[i] = '0;
      end else begin
        cnt_n[i] = cnt[i] + ONE;
      end

      // Outputs are decoded from next-state values so they line up with the
      // counter value registered on the same edge.
      live[i]     = (state_n == ST_LOCKED) && (act_div_n[i] != '0);
      outclk_n[i] = live[i] && (cnt_n[i] < act_high_n[i]);
      clk_en_n[i] = live[i] && (cnt_n[i] == act_div_n[i] - ONE);
    end
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state      <= ST_SETTLE;
      settle_cnt <= '0;
      outclk     <= '0;
      clk_en     <= '0;
      locked     <= 1'b0;
      for (int i = 0; i < NUM_CLOCKS; i++) begin
        sh_div[i]    <= DIV_RST;
        sh_high[i]   <= HIGH_RST;
        sh_phase[i]  <= PHASE_RST;
        act_div[i]   <= DIV_RST;
        act_high[i]  <= HIGH_RST;
        act_phase[i] <= PHASE_RST;
        cnt[i]       <= CNT_RST;
      end
    end else begin
      state      <= state_n;
      settle_cnt <= settle_cnt_n;
      outclk     <= outclk_n;
      clk_en     <= clk_en_n;
      locked     <= (state_n == ST_LOCKED);
      for (int i = 0; i < NUM_CLOCKS; i++) begin
        sh_div[i]    <= sh_div_n[i];
        sh_high[i]   <= sh_high_n[i];
        sh_phase[i]  <= sh_phase_n[i];
        act_div[i]   <= act_div_n[i];
        act_high[i]  <= act_high_n[i];
        act_phase[i] <= act_phase_n[i];
        cnt[i]       <= cnt_n[i];
      end
    end
  end

endmodule

// File: tb/tb_soc_system_clkgen_bank.sv
// tb/tb_soc_system_clkgen_bank.sv - directed table-driven bench for soc_system_clkgen_bank

module tb_soc_system_clkgen_bank;

  localparam int NCLK = 3;
  localparam int CW   = 16;

  logic            refclk;
  logic            rst;
  logic            cfg_wr;
  logic [1:0]      cfg_sel;
  logic [CW-1:0]   cfg_div;
  logic [CW-1:0]   cfg_high;
  logic [CW-1:0]   cfg_phase;
  logic            cfg_apply;
  logic [NCLK-1:0] outclk;
  logic [NCLK-1:0] clk_en;
  logic            locked;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    int            ch;
    logic [CW-1:0] div;
    logic [CW-1:0] high;
    logic [CW-1:0] phase;
    logic [7:0]    out_pat;
    logic [7:0]    en_pat;
    string         name;
  } vec_t;

  vec_t tbl[8];

  logic [NCLK-1:0] d_out[4];
  logic [NCLK-1:0] d_en[4];

  soc_system_clkgen_bank #(
    .NUM_CLOCKS(NCLK),
    .CNT_WIDTH(CW),
    .LOCK_CYCLES(16),
    .DIV_DEFAULT(2),
    .HIGH_DEFAULT(1),
    .PHASE_DEFAULT(0)
  ) dut (
    .refclk(refclk),
    .rst(rst),
    .cfg_wr(cfg_wr),
    .cfg_sel(cfg_sel),
    .cfg_div(cfg_div),
    .cfg_high(cfg_high),
    .cfg_phase(cfg_phase),
    .cfg_apply(cfg_apply),
    .outclk(outclk),
    .clk_en(clk_en),
    .locked(locked)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge refclk);
    @(negedge refclk);
  endtask

  task automatic write_cfg(input int ch, input logic [CW-1:0] d, input logic [CW-1:0] h,
                           input logic [CW-1:0] p);
    cfg_sel   = 2'(ch);
    cfg_div   = d;
    cfg_high  = h;
    cfg_phase = p;
    cfg_wr    = 1'b1;
    step();
    cfg_wr    = 1'b0;
  endtask

  task automatic pulse_apply();
    cfg_apply = 1'b1;
    step();
    cfg_apply = 1'b0;
  endtask

  // Counts edges until locked rises (bounded) and checks outputs stay quiet.
  task automatic wait_lock(input string name);
    int   n;
    logic leak;
    n    = 0;
    leak = 1'b0;
    do begin
      step();
      n++;
      if (!locked) leak = leak | (|outclk) | (|clk_en);
    end while (!locked && n < 40);
    check({name, " lock_edges"}, n, 16);
    check({name, " settle_quiet"}, int'(leak), 0);
  endtask

  initial begin
    tbl[0] = '{2, 16'd0,     16'd1, 16'd0,     8'b0000_0000, 8'b0000_0000, "div0"};
    tbl[1] = '{0, 16'd1,     16'd1, 16'd0,     8'b1111_1111, 8'b1111_1111, "div1"};
    tbl[2] = '{1, 16'd5,     16'd7, 16'd0,     8'b1111_1111, 8'b0000_1000, "div5_high7"};
    tbl[3] = '{2, 16'd3,     16'd1, 16'd9,     8'b1001_0010, 8'b0010_0100, "div3_phase9"};
    tbl[4] = '{0, 16'd2,     16'd0, 16'd0,     8'b0000_0000, 8'b0101_0101, "high0"};
    tbl[5] = '{1, 16'd3,     16'd2, 16'd1,     8'b1011_0110, 8'b0100_1001, "div3_phase1"};
    tbl[6] = '{2, 16'd4,     16'd2, 16'd2,     8'b0011_0011, 8'b0100_0100, "div4_phase2"};
    tbl[7] = '{0, 16'd65535, 16'd1, 16'd65533, 8'b0010_0000, 8'b0100_0000, "divmax_wrap"};

    // ch0 4/2/0, ch1 4/2/2, ch2 default 2/1/0
    d_out[0] = 3'b101; d_out[1] = 3'b001; d_out[2] = 3'b110; d_out[3] = 3'b010;
    d_en[0]  = 3'b000; d_en[1]  = 3'b110; d_en[2]  = 3'b000; d_en[3]  = 3'b101;

    rst = 1'b1; cfg_wr = 1'b0; cfg_sel = '0; cfg_div = '0; cfg_high = '0;
    cfg_phase = '0; cfg_apply = 1'b0;

    // Reset state
    step();
    step();
    check("rst outclk", int'(outclk), 0);
    check("rst clk_en", int'(clk_en), 0);
    check("rst locked", int'(locked), 0);
    rst = 1'b0;
    wait_lock("por");

    // Default divide-by-2 pattern on all channels
    for (int k = 0; k < 8; k++) begin
      if (k > 0) step();
      check($sformatf("dflt outclk k%0d", k), int'(outclk), (k % 2 == 0) ? 7 : 0);
      check($sformatf("dflt clk_en k%0d", k), int'(clk_en), (k % 2 == 0) ? 0 : 7);
    end

    // Shadow write without apply must not disturb running outputs
    write_cfg(0, 16'd0, 16'd0, 16'd0);
    for (int k = 8; k < 12; k++) begin
      if (k > 8) step();
      check($sformatf("noapply outclk k%0d", k), int'(outclk), (k % 2 == 0) ? 7 : 0);
      check($sformatf("noapply clk_en k%0d", k), int'(clk_en), (k % 2 == 0) ? 0 : 7);
      check($sformatf("noapply locked k%0d", k), int'(locked), 1);
    end

    // Two channels with different phase, then relock
    write_cfg(0, 16'd4, 16'd2, 16'd0);
    write_cfg(1, 16'd4, 16'd2, 16'd2);
    pulse_apply();
    check("apply drops locked", int'(locked), 0);
    wait_lock("phase2");
    for (int k = 0; k < 8; k++) begin
      if (k > 0) step();
      check($sformatf("phase2 outclk k%0d", k), int'(outclk), int'(d_out[k % 4]));
      check($sformatf("phase2 clk_en k%0d", k), int'(clk_en), int'(d_en[k % 4]));
    end

    // Out-of-range channel index leaves every channel unchanged
    write_cfg(3, 16'd0, 16'd0, 16'd0);
    pulse_apply();
    wait_lock("badsel");
    for (int k = 0; k < 4; k++) begin
      if (k > 0) step();
      check($sformatf("badsel outclk k%0d", k), int'(outclk), int'(d_out[k]));
      check($sformatf("badsel clk_en k%0d", k), int'(clk_en), int'(d_en[k]));
    end

    // Table of single-channel corner ratios
    for (int r = 0; r < 8; r++) begin
      write_cfg(tbl[r].ch, tbl[r].div, tbl[r].high, tbl[r].phase);
      pulse_apply();
      wait_lock(tbl[r].name);
      for (int k = 0; k < 8; k++) begin
        if (k > 0) step();
        check($sformatf("%s outclk k%0d", tbl[r].name, k), int'(outclk[tbl[r].ch]),
              int'(tbl[r].out_pat[7-k]));
        check($sformatf("%s clk_en k%0d", tbl[r].name, k), int'(clk_en[tbl[r].ch]),
              int'(tbl[r].en_pat[7-k]));
      end
    end

    // Same-cycle write and apply: written value is part of applied set
    cfg_sel = 2'd1; cfg_div = 16'd1; cfg_high = 16'd1; cfg_phase = 16'd0;
    cfg_wr = 1'b1; cfg_apply = 1'b1;
    step();
    cfg_wr = 1'b0; cfg_apply = 1'b0;
    wait_lock("wr_apply");
    for (int k = 0; k < 4; k++) begin
      if (k > 0) step();
      check($sformatf("wr_apply outclk1 k%0d", k), int'(outclk[1]), 1);
      check($sformatf("wr_apply clk_en1 k%0d", k), int'(clk_en[1]), 1);
    end

    // Re-apply during settle restarts the lock count
    pulse_apply();
    for (int k = 0; k < 9; k++) step();
    check("reapply still unlocked", int'(locked), 0);
    pulse_apply();
    wait_lock("reapply");

    // Asynchronous reset mid-operation
    check("prerst outclk1", int'(outclk[1]), 1);
    #2 rst = 1'b1;
    #1;
    check("async outclk", int'(outclk), 0);
    check("async clk_en", int'(clk_en), 0);
    check("async locked", int'(locked), 0);
    @(negedge refclk);
    step();
    rst = 1'b0;
    wait_lock("rerst");
    for (int k = 0; k < 4; k++) begin
      if (k > 0) step();
      check($sformatf("rerst outclk k%0d", k), int'(outclk), (k % 2 == 0) ? 7 : 0);
      check($sformatf("rerst clk_en k%0d", k), int'(clk_en), (k % 2 == 0) ? 0 : 7);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
